// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit bus machine: a 5-state step counter
// plus a halt flag; all control lines are combinational decodes of step and opcode.
module control_sequencer #(
  parameter bit EARLY_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       fi
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

  step_e step_q, step_d;
  logic  halted_q, halted_d;
  ctrl_t ctrl;

  // Final microstep of each opcode; without early reset every instruction takes five steps.
  function automatic step_e last_step(input logic [3:0] op);
    step_e last;
    if (!EARLY_RESET) begin
      last = T4;
    end else begin
      case (op)
        OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last = T2;
        OP_LDA, OP_STA:                               last = T3;
        OP_ADD, OP_SUB:                               last = T4;
        default:                                      last = T1;
      endcase
    end
    return last;
  endfunction

  function automatic step_e incr_step(input step_e s);
    step_e n;
    case (s)
      T0:      n = T1;
      T1:      n = T2;
      T2:      n = T3;
      T3:      n = T4;
      default: n = T0;
    endcase
    return n;
  endfunction

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == last_step(opcode)) begin
        step_d = T0;
      end else begin
        step_d = incr_step(step_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Reset dominates halt, halt dominates microcode; execute steps decode only listed microcode.
  always_comb begin
    ctrl = '0;
    if (clr) begin
      ctrl = '0;
    end else if (halted_q) begin
      ctrl.hlt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          ctrl.co = 1'b1;
          ctrl.mi = 1'b1;
        end
        T1: begin
          ctrl.ro = 1'b1;
          ctrl.ii = 1'b1;
          ctrl.ce = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.io = 1'b1;
              ctrl.mi = 1'b1;
            end
            OP_LDI: begin
              ctrl.io = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_JMP: begin
              ctrl.io = 1'b1;
              ctrl.j  = 1'b1;
            end
            OP_JC: begin
              ctrl.io = 1'b1;
              ctrl.j  = cf;
            end
            OP_JZ: begin
              ctrl.io = 1'b1;
              ctrl.j  = zf;
            end
            OP_OUT: begin
              ctrl.ao = 1'b1;
              ctrl.oi = 1'b1;
            end
            OP_HLT: ctrl.hlt = 1'b1;
            default: ctrl = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ro = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ro = 1'b1;
              ctrl.bi = 1'b1;
            end
            OP_STA: begin
              ctrl.ao = 1'b1;
              ctrl.ri = 1'b1;
            end
            default: ctrl = '0;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.eo = 1'b1;
            ctrl.ai = 1'b1;
            ctrl.fi = 1'b1;
            ctrl.su = (opcode == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign step = step_q;
  assign hlt  = ctrl.hlt;
  assign mi   = ctrl.mi;
  assign ri   = ctrl.ri;
  assign ro   = ctrl.ro;
  assign ii   = ctrl.ii;
  assign io   = ctrl.io;
  assign ai   = ctrl.ai;
  assign ao   = ctrl.ao;
  assign eo   = ctrl.eo;
  assign su   = ctrl.su;
  assign bi   = ctrl.bi;
  assign oi   = ctrl.oi;
  assign ce   = ctrl.ce;
  assign co   = ctrl.co;
  assign j    = ctrl.j;
  assign fi   = ctrl.fi;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_RESET setting,
// hand-computed step/control vectors, plus a per-cycle single-bus-driver check.
module tb_control_sequencer;

  localparam logic [15:0] HLT = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RI  = 16'h2000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] II  = 16'h0800;
  localparam logic [15:0] IO  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] AO  = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080;
  localparam logic [15:0] SU  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] OI  = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] J   = 16'h0002;
  localparam logic [15:0] FI  = 16'h0001;
  localparam logic [15:0] FETCH0 = CO | MI;
  localparam logic [15:0] FETCH1 = RO | II | CE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr1, cf1, zf1, clr0, cf0, zf0;
  logic [3:0] op1, op0;
  logic [2:0] step1, step0;
  logic hlt1, mi1, ri1, ro1, ii1, io1, ai1, ao1, eo1, su1, bi1, oi1, ce1, co1, j1, fi1;
  logic hlt0, mi0, ri0, ro0, ii0, io0, ai0, ao0, eo0, su0, bi0, oi0, ce0, co0, j0, fi0;
  logic [15:0] ctl1, ctl0;
  logic        sel;

  int n_checks = 0;
  int n_errors = 0;

  assign ctl1 = {hlt1, mi1, ri1, ro1, ii1, io1, ai1, ao1, eo1, su1, bi1, oi1, ce1, co1, j1, fi1};
  assign ctl0 = {hlt0, mi0, ri0, ro0, ii0, io0, ai0, ao0, eo0, su0, bi0, oi0, ce0, co0, j0, fi0};

  control_sequencer #(.EARLY_RESET(1'b1)) dut1 (
    .clk(clk), .clr(clr1), .opcode(op1), .cf(cf1), .zf(zf1), .step(step1),
    .hlt(hlt1), .mi(mi1), .ri(ri1), .ro(ro1), .ii(ii1), .io(io1), .ai(ai1), .ao(ao1),
    .eo(eo1), .su(su1), .bi(bi1), .oi(oi1), .ce(ce1), .co(co1), .j(j1), .fi(fi1)
  );

  control_sequencer #(.EARLY_RESET(1'b0)) dut0 (
    .clk(clk), .clr(clr0), .opcode(op0), .cf(cf0), .zf(zf0), .step(step0),
    .hlt(hlt0), .mi(mi0), .ri(ri0), .ro(ro0), .ii(ii0), .io(io0), .ai(ai0), .ao(ao0),
    .eo(eo0), .su(su0), .bi(bi0), .oi(oi0), .ce(ce0), .co(co0), .j(j0), .fi(fi0)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [2:0] s, input logic [15:0] c);
    logic [2:0]  os;
    logic [15:0] oc;
    os = sel ? step1 : step0;
    oc = sel ? ctl1 : ctl0;
    n_checks++;
    assert ({os, oc} === {s, c}) else begin
      n_errors++;
      $error("FAIL %s: observed step=%0d ctl=%04h expected step=%0d ctl=%04h",
             tag, os, oc, s, c);
    end
  endtask

  // Single bus driver, sampled mid-cycle on both instances.
  always @(negedge clk) begin
    n_checks++;
    assert ($countones({co1, ro1, io1, ao1, eo1}) <= 1 &&
            $countones({co0, ro0, io0, ao0, eo0}) <= 1) else begin
      n_errors++;
      $error("FAIL bus_onehot: observed er1=%05b er0=%05b expected at most one set",
             {co1, ro1, io1, ao1, eo1}, {co0, ro0, io0, ao0, eo0});
    end
  end

  initial begin
    sel  = 1'b1;
    clr1 = 1'b1; op1 = 4'h1; cf1 = 1'b0; zf1 = 1'b0;
    clr0 = 1'b1; op0 = 4'h0; cf0 = 1'b0; zf0 = 1'b0;

    // Reset then LDA fetch/execute
    tick(); chk("rst_a", 3'd0, 16'h0);
    tick(); chk("rst_b", 3'd0, 16'h0);
    clr1 = 1'b0; #1;
    chk("lda_t0", 3'd0, FETCH0);
    tick(); chk("lda_t1", 3'd1, FETCH1);
    tick(); chk("lda_t2", 3'd2, IO | MI);
    tick(); chk("lda_t3", 3'd3, RO | AI);
    tick(); chk("lda_wrap", 3'd0, FETCH0);

    // SUB then ADD
    op1 = 4'h3; #1;
    tick(); chk("sub_t1", 3'd1, FETCH1);
    tick(); chk("sub_t2", 3'd2, IO | MI);
    tick(); chk("sub_t3", 3'd3, RO | BI);
    tick(); chk("sub_t4", 3'd4, EO | AI | SU | FI);
    tick(); chk("sub_wrap", 3'd0, FETCH0);
    op1 = 4'h2; #1;
    tick(); tick(); tick();
    chk("add_t3", 3'd3, RO | BI);
    tick(); chk("add_t4", 3'd4, EO | AI | FI);
    tick(); chk("add_wrap", 3'd0, FETCH0);

    // Conditional jumps, taken and not taken
    op1 = 4'h7; cf1 = 1'b0; zf1 = 1'b1; #1;
    tick(); tick(); chk("jc_nt_t2", 3'd2, IO);
    tick(); chk("jc_nt_wrap", 3'd0, FETCH0);
    cf1 = 1'b1; zf1 = 1'b0; #1;
    tick(); tick(); chk("jc_tk_t2", 3'd2, IO | J);
    tick(); chk("jc_tk_wrap", 3'd0, FETCH0);
    op1 = 4'h8; #1;
    tick(); tick(); chk("jz_nt_t2", 3'd2, IO);
    tick(); chk("jz_nt_wrap", 3'd0, FETCH0);
    zf1 = 1'b1; cf1 = 1'b0; #1;
    tick(); tick(); chk("jz_tk_t2", 3'd2, IO | J);
    tick(); chk("jz_tk_wrap", 3'd0, FETCH0);

    // Other short opcodes
    op1 = 4'h6; #1;
    tick(); tick(); chk("jmp_t2", 3'd2, IO | J);
    tick(); chk("jmp_wrap", 3'd0, FETCH0);
    op1 = 4'h5; #1;
    tick(); tick(); chk("ldi_t2", 3'd2, IO | AI);
    tick(); chk("ldi_wrap", 3'd0, FETCH0);
    op1 = 4'hE; #1;
    tick(); tick(); chk("out_t2", 3'd2, AO | OI);
    tick(); chk("out_wrap", 3'd0, FETCH0);
    op1 = 4'h4; #1;
    tick(); tick(); chk("sta_t2", 3'd2, IO | MI);
    tick(); chk("sta_t3", 3'd3, AO | RI);
    tick(); chk("sta_wrap", 3'd0, FETCH0);
    op1 = 4'h0; #1;
    tick(); chk("nop_t1", 3'd1, FETCH1);
    tick(); chk("nop_wrap", 3'd0, FETCH0);
    op1 = 4'hA; #1;
    tick(); chk("undef_t1", 3'd1, FETCH1);
    tick(); chk("undef_wrap", 3'd0, FETCH0);

    // Reset in the middle of ADD
    op1 = 4'h2; #1;
    tick(); tick(); tick(); chk("mid_t3", 3'd3, RO | BI);
    clr1 = 1'b1; #1;
    chk("mid_clr_comb", 3'd3, 16'h0);
    tick(); chk("mid_clr_step", 3'd0, 16'h0);
    clr1 = 1'b0; #1;
    chk("mid_after", 3'd0, FETCH0);

    // Halt, ignore inputs while halted, recover with clr
    op1 = 4'hF; #1;
    tick(); tick(); chk("hlt_t2", 3'd2, HLT);
    for (int i = 0; i < 10; i++) begin
      tick();
      op1 = 4'($urandom_range(0, 15));
      cf1 = 1'($urandom_range(0, 1));
      zf1 = 1'($urandom_range(0, 1));
      #1;
      chk("hlt_frozen", 3'd2, HLT);
    end
    clr1 = 1'b1; #1;
    chk("hlt_clr_comb", 3'd2, 16'h0);
    tick(); clr1 = 1'b0; op1 = 4'h1; #1;
    chk("hlt_recover", 3'd0, FETCH0);

    // EARLY_RESET = 0 instance
    sel = 1'b0;
    chk("er0_rst", 3'd0, 16'h0);
    op0 = 4'h5; clr0 = 1'b0; #1;
    chk("er0_ldi_t0", 3'd0, FETCH0);
    tick(); chk("er0_ldi_t1", 3'd1, FETCH1);
    tick(); chk("er0_ldi_t2", 3'd2, IO | AI);
    tick(); chk("er0_ldi_t3", 3'd3, 16'h0);
    tick(); chk("er0_ldi_t4", 3'd4, 16'h0);
    tick(); chk("er0_ldi_wrap", 3'd0, FETCH0);
    op0 = 4'h1; #1;
    tick(); tick(); tick(); chk("er0_lda_t3", 3'd3, RO | AI);
    tick(); chk("er0_lda_t4", 3'd4, 16'h0);
    tick(); chk("er0_lda_wrap", 3'd0, FETCH0);
    op0 = 4'hF; #1;
    tick(); tick(); chk("er0_hlt_t2", 3'd2, HLT);
    tick(); tick(); chk("er0_hlt_frozen", 3'd2, HLT);
    clr0 = 1'b1; tick(); clr0 = 1'b0; #1;
    chk("er0_hlt_recover", 3'd0, FETCH0);

    // Sweep every opcode and flag combination on both instances for the bus check
    for (int o = 0; o < 16; o++) begin
      for (int f = 0; f < 4; f++) begin
        op1 = 4'(o); op0 = 4'(o);
        cf1 = f[0]; cf0 = f[0]; zf1 = f[1]; zf0 = f[1];
        clr1 = 1'b1; clr0 = 1'b1;
        tick();
        clr1 = 1'b0; clr0 = 1'b0;
        for (int c = 0; c < 6; c++) tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
